// File: rtl/ram_loader_pkg.sv
// Shared definitions for the boot-time RAM loader and the CPU/RAM top level:
// loader state encoding and the bus width constants.
package ram_loader_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/ram_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream and writes it into RAM
// from BASE_ADDR upward while holding the CPU in reset. LOADER_CHECKSUM_EN adds a trailing checksum byte.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              c_ri,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Stream handshake: a byte moves on a rising edge where in_valid and in_ready are both high;
    // the sender holds in_data stable until then. in_ready is registered and depends only on state.
    state_e              state_q;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [8:0]          remaining_q, remaining_d;
    logic                in_ready_q;
    logic [ADDR_W-1:0]   addr_bus_q;
    logic [DATA_W-1:0]   bus_out_q;
    logic                bus_oe_q;
    logic                c_ri_q;
    logic                cpu_hold_q;
    logic                done_q;
    logic                handshake;

    assign handshake = in_valid && in_ready_q;

    always_comb begin
        addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
        remaining_d = remaining_q - 9'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b0;
            addr_bus_q  <= '0;
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
            c_ri_q      <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            // The bus is only driven for the single WRITE cycle that follows a data handshake.
            addr_bus_q <= '0;
            bus_out_q  <= '0;
            bus_oe_q   <= 1'b0;
            c_ri_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LEN;
                        in_ready_q <= 1'b1;
                        addr_cnt_q <= BASE_ADDR;
                    end
                end
                LEN: begin
                    if (handshake) begin
                        // A zero header means a full 256-byte image.
                        remaining_q <= (in_data == '0) ? 9'd256 : {1'b0, in_data};
                        state_q     <= DATA;
                    end
                end
                DATA: begin
                    if (handshake) begin
                        state_q    <= WRITE;
                        in_ready_q <= 1'b0;
                        addr_bus_q <= addr_cnt_q;
                        bus_out_q  <= in_data;
                        bus_oe_q   <= 1'b1;
                        c_ri_q     <= 1'b1;
                    end
                end
                WRITE: begin
                    addr_cnt_q  <= addr_cnt_d;
                    remaining_q <= remaining_d;
                    if (remaining_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q    <= CSUM;
                        in_ready_q <= 1'b1;
`else
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
`endif
                    end else begin
                        state_q    <= DATA;
                        in_ready_q <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (handshake) begin
                        state_q    <= DONE;
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q;

    assign sum_d = sum_q + in_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                sum_q <= '0;
            end else if (state_q == DATA && handshake) begin
                sum_q <= sum_d;
            end
            if (state_q == CSUM && handshake) begin
                err_q <= (in_data != sum_q);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign addr_bus  = addr_bus_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign c_ri      = c_ri_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: two instances (base 00 and base FE) see the same stream;
// every RAM write is recorded and compared with an expected queue built from the stimulus.
module tb_ram_loader;
    import ram_loader_pkg::*;

    localparam logic [7:0] BASE_A = 8'h00;
    localparam logic [7:0] BASE_B = 8'hFE;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       a_in_ready, a_bus_oe, a_c_ri, a_cpu_hold, a_done, a_err;
    logic [7:0] a_addr_bus, a_bus_out;
    logic [2:0] a_state;
    logic       b_in_ready, b_bus_oe, b_c_ri, b_cpu_hold, b_done, b_err;
    logic [7:0] b_addr_bus, b_bus_out;
    logic [2:0] b_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] got_a[$];
    logic [15:0] got_b[$];
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    logic [7:0]  stim_q[$];

    ram_loader #(.BASE_ADDR(BASE_A)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .addr_bus(a_addr_bus), .bus_out(a_bus_out), .bus_oe(a_bus_oe),
        .c_ri(a_c_ri), .cpu_hold(a_cpu_hold), .done(a_done), .err(a_err), .dbg_state(a_state)
    );

    ram_loader #(.BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .addr_bus(b_addr_bus), .bus_out(b_bus_out), .bus_oe(b_bus_oe),
        .c_ri(b_c_ri), .cpu_hold(b_cpu_hold), .done(b_done), .err(b_err), .dbg_state(b_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // write monitor with bus-idle invariant
    always @(negedge clk) begin
        if (a_c_ri === 1'b1) got_a.push_back({a_addr_bus, a_bus_out});
        if (b_c_ri === 1'b1) got_b.push_back({b_addr_bus, b_bus_out});
        total++;
        if (a_bus_oe !== a_c_ri || (a_c_ri !== 1'b1 && {a_addr_bus, a_bus_out} !== 16'h0)) begin
            $display("FAIL bus_idle_a oe=%b c_ri=%b addr=%h data=%h required oe==c_ri and zero bus when idle",
                     a_bus_oe, a_c_ri, a_addr_bus, a_bus_out);
            bad++;
        end
        total++;
        if (b_bus_oe !== b_c_ri || (b_c_ri !== 1'b1 && {b_addr_bus, b_bus_out} !== 16'h0)) begin
            $display("FAIL bus_idle_b oe=%b c_ri=%b addr=%h data=%h required oe==c_ri and zero bus when idle",
                     b_bus_oe, b_c_ri, b_addr_bus, b_bus_out);
            bad++;
        end
    end

    // expected-value model
    function automatic void build_exp(input int n);
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < n; i++) begin
            exp_a.push_back({BASE_A + 8'(i), stim_q[i+1]});
            exp_b.push_back({BASE_B + 8'(i), stim_q[i+1]});
        end
    endfunction

    function automatic logic [7:0] csum_of(input int n);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 1; i <= n; i++) s = s + stim_q[i];
        return s;
    endfunction

    // driver tasks
    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        got_a.delete();
        got_b.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        in_data = b;
        in_valid = 1'b1;
        n = 0;
        while (a_in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout in_ready=%b required=1", a_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream();
        for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i]);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (a_done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL done_timeout done=%b required=1", a_done);
        end
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a_in_ready, a_addr_bus, a_bus_out, a_bus_oe, a_c_ri, a_cpu_hold, a_done, a_err, a_state}
            !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_a rdy=%b addr=%h data=%h oe=%b cri=%b hold=%b done=%b err=%b st=%0d required 0,00,00,0,0,1,0,0,0",
                     a_in_ready, a_addr_bus, a_bus_out, a_bus_oe, a_c_ri, a_cpu_hold, a_done, a_err, a_state);
        end
        total++;
        if ({b_in_ready, b_addr_bus, b_bus_out, b_bus_oe, b_c_ri, b_cpu_hold, b_done, b_err, b_state}
            !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_b rdy=%b cri=%b hold=%b done=%b st=%0d required 0,0,1,0,0",
                     b_in_ready, b_c_ri, b_cpu_hold, b_done, b_state);
        end
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (a_in_ready !== 1'b0 || a_state !== 3'(IDLE)) begin
            bad++;
            $display("FAIL idle_hold rdy=%b st=%0d required rdy=0 st=0", a_in_ready, a_state);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        stim_q = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
        build_exp(3);
`ifdef LOADER_CHECKSUM_EN
        stim_q.push_back(csum_of(3));
`endif
        pulse_start();
        send_stream();
`ifndef LOADER_CHECKSUM_EN
        total++;
        if (a_done !== 1'b0 || a_cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL done_early done=%b hold=%b required done=0 hold=1", a_done, a_cpu_hold);
        end
        @(posedge clk);
        #1;
`endif
        total++;
        if ({a_done, a_cpu_hold, b_done, b_cpu_hold, a_err} !== 5'b10100) begin
            bad++;
            $display("FAIL basic_done done=%b hold=%b done_b=%b hold_b=%b err=%b required 1,0,1,0,0",
                     a_done, a_cpu_hold, b_done, b_cpu_hold, a_err);
        end
        total++;
        if (got_a.size() != 3 || got_b.size() != 3) begin
            bad++;
            $display("FAIL basic_count got=%0d/%0d required=3", got_a.size(), got_b.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
                    bad++;
                    $display("FAIL basic_write[%0d] got=%h/%h required=%h/%h", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
                end
            end
        end
        in_data = 8'h55;
        in_valid = 1'b1;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (a_state !== 3'(DONE) || a_in_ready !== 1'b0 || a_done !== 1'b1 || got_a.size() != 3) begin
            bad++;
            $display("FAIL done_sticky st=%0d rdy=%b done=%b writes=%0d required st=5 rdy=0 done=1 writes=3",
                     a_state, a_in_ready, a_done, got_a.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        stim_q = '{8'h03, 8'h11, 8'h22, 8'h33};
        build_exp(3);
`ifdef LOADER_CHECKSUM_EN
        stim_q.push_back(csum_of(3));
`endif
        pulse_start();
        send_stream();
        wait_done();
        total++;
        if (got_b.size() != 3) begin
            bad++;
            $display("FAIL wrap_count got=%0d required=3", got_b.size());
        end else if (got_b[0] !== 16'hFE11 || got_b[1] !== 16'hFF22 || got_b[2] !== 16'h0033) begin
            bad++;
            $display("FAIL wrap_write got=%h %h %h required=fe11 ff22 0033", got_b[0], got_b[1], got_b[2]);
        end
    endtask

    task automatic test_full_256();
        int t0;
        do_reset();
        stim_q = '{8'h00};
        for (int i = 0; i < 256; i++) stim_q.push_back(8'(i * 7 + 3));
        build_exp(256);
`ifdef LOADER_CHECKSUM_EN
        stim_q.push_back(csum_of(256));
`endif
        pulse_start();
        t0 = cyc;
        send_stream();
        wait_done();
        total++;
`ifdef LOADER_CHECKSUM_EN
        if (cyc - t0 != 514) begin
`else
        if (cyc - t0 != 513) begin
`endif
            bad++;
            $display("FAIL full_latency cycles=%0d required=513 (+1 with checksum)", cyc - t0);
        end
        total++;
        if (got_a.size() != 256 || got_b.size() != 256) begin
            bad++;
            $display("FAIL full_count got=%0d/%0d required=256", got_a.size(), got_b.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                total++;
                if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
                    bad++;
                    $display("FAIL full_write[%0d] got=%h/%h required=%h/%h", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
                end
            end
            total++;
            if (got_a[255][15:8] !== 8'hFF || got_b[255][15:8] !== 8'hFD) begin
                bad++;
                $display("FAIL full_last_addr got=%h/%h required=ff/fd", got_a[255][15:8], got_b[255][15:8]);
            end
        end
    endtask

    task automatic test_toggle();
        do_reset();
        stim_q = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        build_exp(4);
`ifdef LOADER_CHECKSUM_EN
        stim_q.push_back(csum_of(4));
`endif
        pulse_start();
        for (int i = 0; i < stim_q.size(); i++) begin
            send_byte(stim_q[i]);
            in_valid = 1'b0;
            if (i == 2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_done();
        total++;
        if (got_a.size() != 4) begin
            bad++;
            $display("FAIL toggle_count got=%0d required=4", got_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
                    bad++;
                    $display("FAIL toggle_write[%0d] got=%h/%h required=%h/%h", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b0;
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({a_state, a_cpu_hold, a_c_ri, a_in_ready, a_done} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_state st=%0d hold=%b cri=%b rdy=%b done=%b required 0,1,0,0,0",
                     a_state, a_cpu_hold, a_c_ri, a_in_ready, a_done);
        end
        total++;
        if (got_a.size() != 2 || got_a[0] !== 16'h0011 || got_a[1] !== 16'h0122) begin
            bad++;
            $display("FAIL midreset_writes count=%0d required 2 writes 0011 0122", got_a.size());
        end
        start = 1'b0;
        reset = 1'b1;
        got_a.delete();
        got_b.delete();
        stim_q = '{8'h02, 8'h77, 8'h88};
        build_exp(2);
`ifdef LOADER_CHECKSUM_EN
        stim_q.push_back(csum_of(2));
`endif
        pulse_start();
        send_stream();
        wait_done();
        total++;
        if (got_a.size() != 2 || got_a[0] !== exp_a[0] || got_a[1] !== exp_a[1] ||
            got_b[0] !== exp_b[0] || got_b[1] !== exp_b[1]) begin
            bad++;
            $display("FAIL reload_writes count=%0d first=%h required 2 writes %h %h",
                     got_a.size(), got_a[0], exp_a[0], exp_a[1]);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        stim_q = '{8'h02, 8'h10, 8'h20, 8'h30};
        pulse_start();
        send_stream();
        wait_done();
        total++;
        if ({a_err, a_done, a_cpu_hold} !== 3'b010) begin
            bad++;
            $display("FAIL csum_good err=%b done=%b hold=%b required 0,1,0", a_err, a_done, a_cpu_hold);
        end
        do_reset();
        stim_q = '{8'h02, 8'h10, 8'h20, 8'h31};
        pulse_start();
        send_stream();
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a_err, a_done, a_cpu_hold, b_err} !== 4'b1101) begin
            bad++;
            $display("FAIL csum_bad err=%b done=%b hold=%b err_b=%b required 1,1,0,1", a_err, a_done, a_cpu_hold, b_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_full_256();
        test_toggle();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Boot-time program loader sitting directly upstream of the RAM on the CPU's address/data bus. It accepts a byte stream (length header followed by program bytes) over a valid/ready handshake and writes the bytes into consecutive RAM locations starting at a base address. It holds the CPU in reset for the whole load, then releases it and drives nothing further on the bus.

## Interface
Parameters:
- BASE_ADDR, 8'h00, first RAM address written; subsequent addresses increment modulo 256.

Ports:
- clk  input  1  system clock; all state updates on its rising edge, same edge on which the RAM samples writes.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte this cycle.
- addr_bus  output  8  RAM address; 8'h00 when not writing.
- bus_out  output  8  RAM write data; 8'h00 when not writing.
- bus_oe  output  1  loader drives the data bus; the top level tri-states bus_out onto bus with this signal.
- c_ri  output  1  RAM write enable; high exactly one cycle per program byte.
- cpu_hold  output  1  drives the CPU reset input; high holds the CPU in reset.
- done  output  1  load complete.
- err  output  1  checksum mismatch (see Configuration).

## Operation
- States: IDLE, LEN, DATA, WRITE, CSUM (macro only), DONE.
- IDLE: in_ready=0, cpu_hold=1. start -> LEN; address counter <= BASE_ADDR; running sum <= 0.
- LEN: in_ready=1. On handshake, remaining <= in_data, where 0 encodes 256 (9-bit counter). -> DATA.
- DATA: in_ready=1. On handshake, capture in_data into the write register and add it to the running sum mod 256. -> WRITE.
- WRITE: in_ready=0; addr_bus=address counter, bus_out=captured byte, bus_oe=1, c_ri=1. Then address += 1 (wraps 8'hFF -> 8'h00) and remaining -= 1. If remaining is now 0: -> CSUM when the macro is defined, else -> DONE. Otherwise -> DATA.
- DONE: cpu_hold=0, done=1, in_ready=0; bus released. Stays in DONE until reset. start is ignored.
- start outside IDLE is ignored. in_valid without in_ready is not consumed; the sender holds the byte.

## Timing
- Reset values: state=IDLE, in_ready=0, addr_bus=0, bus_out=0, bus_oe=0, c_ri=0, cpu_hold=1, done=0, err=0.
- A handshake in DATA on edge k produces c_ri=1 during cycle k+1. The RAM captures the byte on edge k+1.
- Peak throughput: one byte per 2 cycles. A full 256-byte load with in_valid held high takes 1 (start) + 1 (LEN) + 512 cycles.
- cpu_hold falls on the same edge on which done rises.
- reset low mid-load: the next edge returns the block to IDLE with all reset values. Bytes already written stay in RAM.
- A simultaneous start and reset low: reset wins.

## Configuration
- LOADER_CHECKSUM_EN defined: after the last data byte, CSUM (in_ready=1) accepts one more byte. err <= (byte != running sum); -> DONE. err holds until reset. cpu_hold still releases.
- Not defined: no CSUM state and no trailing byte consumed; err is tied to 0.

## Structure
- Shared package: state enum (IDLE, LEN, DATA, WRITE, CSUM, DONE) and the width constants ADDR_W=8 and DATA_W=8, shared with the CPU/RAM top level.
- Single module; no sub-module needed. The bus tri-state lives in the top level, not in this block.

## Test plan
- Reset, start, then stream 03, AA, BB, CC with in_valid held high -> c_ri pulses at addresses 00, 01, 02 with data AA, BB, CC. done=1 and cpu_hold=0 two cycles after the CC handshake.
- BASE_ADDR=8'hFE, stream 03, 11, 22, 33 -> writes to FE, FF, 00 (wrap-around).
- Header 00 followed by 256 bytes -> 256 c_ri pulses; the final write goes to BASE_ADDR+255.
- Toggle in_valid every other cycle and pulse start mid-load -> no duplicate or lost bytes; the extra start is ignored.
- Pull reset low after 2 of 5 data bytes -> next cycle IDLE, cpu_hold=1, c_ri=0. A fresh start reloads correctly.
- LOADER_CHECKSUM_EN: stream 02, 10, 20, 30 -> err=0. Stream 02, 10, 20, 31 -> err=1. Both cases end with done=1.
